simon64_96_seq_ctrl: RTL and testbench
======================================

# simon64_96_seq_ctrl

Sequential controller for SIMON64/96: one round per clock, with an on-chip round-key store that is filled by iterative key expansion. It accepts a 96-bit key and then any number of 64-bit blocks, each tagged encrypt or decrypt, over valid/ready handshakes. It is the area-efficient, clocked counterpart to the fully unrolled combinational SIMON64/96 datapath.

## Interface
Parameters: none; geometry is fixed (n=32, m=3, T=42, z-sequence z2).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key offered
- key_ready  out  1  key can be accepted
- key  in  96  k2=key[95:64], k1=key[63:32], k0=key[31:0]
- in_valid  in  1  block offered
- in_ready  out  1  block can be accepted
- in_mode  in  1  1=encrypt, 0=decrypt; sampled with the block
- in_text  in  64  x=in_text[63:32], y=in_text[31:0]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_text  out  64  result {x,y}
- busy  out  1  state is KEYEXP, RUN or DONE

## Operation
- States:
  - NOKEY: after reset; no key is loaded.
  - KEYEXP: key expansion in progress.
  - READY: key loaded; idle.
  - RUN: rounds in progress.
  - DONE: result held on the output.
- Key store: 42 x 32-bit words, k[0..41]. k[0..2] are loaded directly from `key`.
- Expansion, for i = 3..41:
  - tmp = ROR3(k[i-1])
  - k[i] = k[i-3] ^ tmp ^ ROR1(tmp) ^ 32'hFFFFFFFC ^ z2[(i-3)]
  - z2 is 10101111011100000011010010011000101000010001111110010110110011, z2[0] = leftmost bit.
  - One key is written per cycle; a 6-bit counter runs 3..41.
- Encrypt round r = 0..41: x' = y ^ f(x) ^ k[r], y' = x.
- Decrypt round r = 41..0: x' = y, y' = x ^ f(y) ^ k[r].
- f(v) = (ROL1(v) & ROL8(v)) ^ ROL2(v). All arithmetic is 32-bit XOR/AND/rotate; there are no carries.
- Ready signals:
  - key_ready = NOKEY | (READY & ~in_valid). A block has priority over a key in READY.
  - in_ready = READY.
- Transitions:
  - NOKEY/READY, key handshake -> KEYEXP
  - KEYEXP, after k[41] is written -> READY
  - READY, block handshake -> RUN
  - RUN, after the 42nd round -> DONE
  - DONE, out handshake -> READY
- A new key replaces the whole store. Blocks are never accepted during KEYEXP, RUN or DONE.
- out_text is registered. It is updated only on the RUN->DONE transition and holds its value while out_valid & ~out_ready.
- Reset mid-operation: all state returns to reset values and the key store is marked invalid (NOKEY). Stored words need not be cleared.

## Timing
- Reset values:
  - key_ready=1
  - in_ready=0
  - out_valid=0
  - out_text=0
  - busy=0
- Key latency:
  - Key handshake at edge E0.
  - k[3..41] are written at edges E1..E39.
  - State is READY after E39; in_ready=1 in the following cycle.
- Block latency:
  - Block handshake at edge E0.
  - Rounds are applied at edges E1..E42.
  - out_valid=1 from E42 until the edge where out_ready=1.
  - Back in READY after that edge. Minimum turnaround is 44 cycles per block.
- out_valid never drops without a handshake. out_text stays stable while out_valid=1.
- Round counter: 6 bits. Encrypt counts up 0..41; decrypt counts down 41..0. It never wraps past its end value.

## Configuration
- SIMON_UNROLL2_EN defined:
  - Two rounds per clock, using two cascaded round functions and two key-store read ports.
  - Block latency is 21 cycles: out_valid at E21.
  - Key expansion is unchanged at 39 cycles.
- Undefined: one round per clock, as specified above.
- The interface and handshake rules are identical in both builds.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> key_ready=1, in_ready=0, out_valid=0, out_text=0, busy=0 immediately (asynchronous).
- Encrypt: key=96'h131211100b0a090803020100, encrypt in_text=64'h6f7220676e696c63 -> out_text=64'h5ca2e27f111a8fc8; out_valid at E42 (E21 with SIMON_UNROLL2_EN); in_ready high 39 cycles after the key handshake.
- Decrypt: same key, decrypt 64'h5ca2e27f111a8fc8 -> 64'h6f7220676e696c63. Then 20 random blocks encrypt-then-decrypt must round-trip.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_text stable, in_ready=0, key_ready=0; release -> READY the next cycle.
- Contention: key_valid=1 and in_valid=1 together in READY -> block accepted, key_ready=0. Key accepted only after DONE->READY with in_valid=0; the next block uses the new key.
- Reset during RUN (round 20) and during KEYEXP -> NOKEY; in_ready=0 until a fresh key completes expansion; no stale out_valid.

Source files
------------

// File: rtl/simon64_96_seq_ctrl.sv
// simon64_96_seq_ctrl
//   Iterative SIMON64/96 engine: applies one round per clock (two with
//   SIMON_UNROLL2_EN defined) using a 42-word round-key store that is filled
//   by iterative key expansion, one word per clock.
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   key_valid/key_ready    96-bit key handshake; key = {k2, k1, k0}
//   in_valid/in_ready      64-bit block handshake; in_mode 1=encrypt 0=decrypt
//   in_text                {x, y}
//   out_valid/out_ready    result handshake; out_text = {x, y}, registered
//   busy                   key expansion, rounds, or result pending
// Build option: SIMON_UNROLL2_EN selects two cascaded rounds per clock.
module simon64_96_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [95:0] key,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [63:0] in_text,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_text,
    output logic        busy
);

    typedef enum logic [2:0] {S_NOKEY, S_KEYEXP, S_READY, S_RUN, S_DONE} state_t;

    // z2[0] is the MSB of this literal.
    localparam logic [61:0] Z2       = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [5:0]  LAST_KEY = 6'd41;
`ifdef SIMON_UNROLL2_EN
    localparam logic [5:0]  STEP     = 6'd2;
    localparam logic [5:0]  ENC_LAST = 6'd40;
    localparam logic [5:0]  DEC_LAST = 6'd1;
`else
    localparam logic [5:0]  STEP     = 6'd1;
    localparam logic [5:0]  ENC_LAST = 6'd41;
    localparam logic [5:0]  DEC_LAST = 6'd0;
`endif

    function automatic logic [31:0] f_fn(input logic [31:0] v);
        return ({v[30:0], v[31]} & {v[23:0], v[31:24]}) ^ {v[29:0], v[31:30]};
    endfunction

    function automatic logic [63:0] enc_round(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] k);
        return {y ^ f_fn(x) ^ k, x};
    endfunction

    function automatic logic [63:0] dec_round(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] k);
        return {y, x ^ f_fn(y) ^ k};
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  kcnt_q, kcnt_d;
    logic [5:0]  rnd_q, rnd_d;
    logic        enc_q, enc_d;
    logic [31:0] x_q, x_d, y_q, y_d;
    logic [63:0] out_text_q, out_text_d;
    logic        nokey_q, in_ready_q, out_valid_q, busy_q;

    logic [31:0] ks_q [0:41];

    logic        key_fire, blk_fire;
    logic [5:0]  kidx_m1, kidx_m3, z_idx;
    logic [31:0] tmp, ks_new, k_a;
    logic [63:0] r1, r2;
    logic [5:0]  rnd_last;

    assign key_ready = nokey_q | (in_ready_q & ~in_valid);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_text  = out_text_q;
    assign busy      = busy_q;

    assign key_fire = key_valid & key_ready;
    assign blk_fire = in_valid & in_ready_q;

    // Key expansion word for index kcnt_q.
    always_comb begin
        kidx_m1 = kcnt_q - 6'd1;
        kidx_m3 = kcnt_q - 6'd3;
        z_idx   = 6'd61 - kidx_m3;
        tmp     = {ks_q[kidx_m1][2:0], ks_q[kidx_m1][31:3]};
        ks_new  = ks_q[kidx_m3] ^ tmp ^ {tmp[0], tmp[31:1]} ^ 32'hFFFFFFFC ^ {31'b0, Z2[z_idx]};
    end

    // Round datapath; the unrolled build chains a second round on the
    // neighbouring key in the direction of travel.
    always_comb begin
        k_a      = ks_q[rnd_q];
        r1       = enc_q ? enc_round(x_q, y_q, k_a) : dec_round(x_q, y_q, k_a);
        rnd_last = enc_q ? ENC_LAST : DEC_LAST;
`ifdef SIMON_UNROLL2_EN
        r2 = enc_q ? enc_round(r1[63:32], r1[31:0], ks_q[rnd_q + 6'd1])
                   : dec_round(r1[63:32], r1[31:0], ks_q[rnd_q - 6'd1]);
`else
        r2 = r1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        kcnt_d     = kcnt_q;
        rnd_d      = rnd_q;
        enc_d      = enc_q;
        x_d        = x_q;
        y_d        = y_q;
        out_text_d = out_text_q;
        case (state_q)
            S_NOKEY: begin
                if (key_fire) begin
                    state_d = S_KEYEXP;
                    kcnt_d  = 6'd3;
                end
            end
            S_KEYEXP: begin
                if (kcnt_q == LAST_KEY) state_d = S_READY;
                else                    kcnt_d  = kcnt_q + 6'd1;
            end
            S_READY: begin
                if (blk_fire) begin
                    state_d    = S_RUN;
                    enc_d      = in_mode;
                    rnd_d      = in_mode ? 6'd0 : LAST_KEY;
                    {x_d, y_d} = in_text;
                end else if (key_fire) begin
                    state_d = S_KEYEXP;
                    kcnt_d  = 6'd3;
                end
            end
            S_RUN: begin
                {x_d, y_d} = r2;
                if (rnd_q == rnd_last) begin
                    state_d    = S_DONE;
                    out_text_d = r2;
                end else begin
                    rnd_d = enc_q ? rnd_q + STEP : rnd_q - STEP;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_READY;
            end
            default: state_d = S_NOKEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_NOKEY;
            kcnt_q      <= '0;
            rnd_q       <= '0;
            enc_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            out_text_q  <= '0;
            nokey_q     <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kcnt_q      <= kcnt_d;
            rnd_q       <= rnd_d;
            enc_q       <= enc_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_text_q  <= out_text_d;
            nokey_q     <= (state_d == S_NOKEY);
            in_ready_q  <= (state_d == S_READY);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d == S_KEYEXP) || (state_d == S_RUN) || (state_d == S_DONE);
        end
    end

    // Key store is not reset; validity is tracked by the FSM.
    always_ff @(posedge clk) begin
        if (key_fire) begin
            ks_q[0] <= key[31:0];
            ks_q[1] <= key[63:32];
            ks_q[2] <= key[95:64];
        end else if (state_q == S_KEYEXP) begin
            ks_q[kcnt_q] <= ks_new;
        end
    end

endmodule

// File: tb/tb_simon64_96_seq_ctrl.sv
module tb_simon64_96_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [95:0] key = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [63:0] in_text = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_text;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SIMON_UNROLL2_EN
    localparam int BLK_LAT = 21;
`else
    localparam int BLK_LAT = 42;
`endif
    localparam int          KEY_LAT = 39;
    localparam logic [95:0] KEY_A   = 96'h131211100b0a090803020100;
    localparam logic [95:0] KEY_B   = 96'hdeadbeef0123456789abcdef;
    localparam logic [63:0] PT      = 64'h6f7220676e696c63;
    localparam logic [63:0] CT      = 64'h5ca2e27f111a8fc8;

    typedef struct {
        string       name;
        logic        mode;
        logic [63:0] text;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [4];

    simon64_96_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_text   (in_text),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_handshake(input logic [95:0] k);
        int n = 0;
        while (!key_ready && n < 300) begin tick(); n++; end
        check("key_ready_wait", key_ready, 1);
        key       = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_in_ready(output int n);
        n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
    endtask

    task automatic load_key(input logic [95:0] k);
        int n;
        key_handshake(k);
        wait_in_ready(n);
        check("key_latency", n, KEY_LAT);
    endtask

    task automatic start_block(input logic mode, input logic [63:0] text);
        int n = 0;
        while (!in_ready && n < 300) begin tick(); n++; end
        check("in_ready_wait", in_ready, 1);
        in_mode  = mode;
        in_text  = text;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin tick(); n++; end
    endtask

    task automatic do_block(input logic mode, input logic [63:0] text, output logic [63:0] res);
        int n;
        start_block(mode, text);
        wait_out(n);
        check("block_latency", n, BLK_LAT);
        res       = out_text;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_out", in_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"}, key_ready, 1);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_text"},  out_text,  0);
        check({tag, "_busy"},      busy,      0);
    endtask

    initial begin
        logic [63:0] res, c, p, q;
        int          n, bad;

        vecs[0] = '{"enc_kat",   1'b1, PT, CT};
        vecs[1] = '{"dec_kat",   1'b0, CT, PT};
        vecs[2] = '{"dec_again", 1'b0, CT, PT};
        vecs[3] = '{"enc_again", 1'b1, PT, CT};

        // Power-on reset
        #12;
        check_reset_outputs("por");
        #8 rst_n = 1'b1;
        tick();

        load_key(KEY_A);

        foreach (vecs[i]) begin
            do_block(vecs[i].mode, vecs[i].text, res);
            check(vecs[i].name, res, vecs[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            p = {$urandom, $urandom};
            do_block(1'b1, p, c);
            do_block(1'b0, c, q);
            check("roundtrip", q, p);
        end

        // Backpressure: result must hold for 10 cycles without a handshake
        start_block(1'b1, PT);
        wait_out(n);
        check("bp_latency", n, BLK_LAT);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_text !== CT || in_ready !== 1'b0 || key_ready !== 1'b0 || out_valid !== 1'b1)
                bad++;
            tick();
        end
        check("bp_hold", bad, 0);
        check("bp_text", out_text, CT);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // Reset in the middle of RUN
        start_block(1'b1, PT);
        repeat (20) tick();
        check("run_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_run");
        #2 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || key_ready !== 1'b1) bad++;
        end
        check("rst_run_nokey", bad, 0);

        // Reset in the middle of KEYEXP
        key_handshake(KEY_B);
        repeat (10) tick();
        check("keyexp_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_kexp");
        #2 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (in_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst_kexp_nokey", bad, 0);

        load_key(KEY_B);

        // Contention: block wins, key waits for the return to READY
        key       = KEY_A;
        key_valid = 1'b1;
        in_mode   = 1'b1;
        in_text   = PT;
        in_valid  = 1'b1;
        #1;
        check("cont_key_ready", key_ready, 0);
        check("cont_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("cont_block_taken", in_ready, 0);
        check("cont_busy", busy, 1);
        check("cont_key_ready_run", key_ready, 0);
        wait_out(n);
        check("cont_latency", n, BLK_LAT);
        check("cont_old_key_used", out_text != CT, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("cont_key_ready_after", key_ready, 1);
        tick();
        key_valid = 1'b0;
        check("cont_keyexp_busy", busy, 1);
        wait_in_ready(n);
        check("cont_key_latency", n, KEY_LAT);
        do_block(1'b1, PT, res);
        check("cont_new_key", res, CT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
